// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Read data returned to the master when the slave never answers
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  // Completion pulse pattern for the granted master index
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer advanced
// only when the parent accepts the grant (update strobe).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // High when master 1 won the previous grant, so master 0 wins the next tie.
  // Resets high so the very first tie goes to master 0.
  logic last_is_1;

  // Pick a winner: lone requester wins, a tie goes to the master not served last
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_is_1 ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember who was granted whenever a grant is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_is_1 <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      last_is_1 <= grant[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-slave memory bus arbiter with round-robin grant,
// slave wait timeout and registered outputs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate on any m_valid bit
// BUSY    | request presented on s_*; wait for s_ready or timeout
// DONE    | one-cycle m_ready pulse to the granted master
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            m_valid,
  input  logic [2*ADDR_W-1:0]   m_addr,
  input  logic [2*DATA_W-1:0]   m_wdata,
  input  logic [2*DATA_W/8-1:0] m_wstrb,
  output logic [1:0]            m_ready,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  s_valid,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_ready,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  timeout_irq
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  // Last BUSY cycle the slave is allowed; no s_ready here means timeout
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(TIMEOUT_RDATA);

  arb_state_t         state, state_nxt;
  logic               gidx, gidx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         arb_grant;
  logic               arb_update;

  logic               s_valid_nxt;
  logic [ADDR_W-1:0]  s_addr_nxt;
  logic [DATA_W-1:0]  s_wdata_nxt;
  logic [STRB_W-1:0]  s_wstrb_nxt;
  logic [1:0]         m_ready_nxt;
  logic [DATA_W-1:0]  m_rdata_nxt;
  logic               irq_nxt;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (m_valid),
    .update (arb_update),
    .grant  (arb_grant)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; s_ready takes precedence over timeout expiry
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|m_valid) state_nxt = ST_BUSY;
      ST_BUSY: if (s_ready || (cnt == CNT_LAST)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values for every registered output and the datapath holding registers
  always_comb begin
    arb_update  = 1'b0;
    gidx_nxt    = gidx;
    cnt_nxt     = cnt;
    s_valid_nxt = s_valid;
    s_addr_nxt  = s_addr;
    s_wdata_nxt = s_wdata;
    s_wstrb_nxt = s_wstrb;
    m_ready_nxt = 2'b00;
    m_rdata_nxt = m_rdata;
    irq_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_grant != 2'b00) begin
          arb_update  = 1'b1;
          gidx_nxt    = arb_grant[1];
          cnt_nxt     = '0;
          s_valid_nxt = 1'b1;
          if (arb_grant[1]) begin
            s_addr_nxt  = m_addr[2*ADDR_W-1:ADDR_W];
            s_wdata_nxt = m_wdata[2*DATA_W-1:DATA_W];
            s_wstrb_nxt = m_wstrb[2*STRB_W-1:STRB_W];
          end else begin
            s_addr_nxt  = m_addr[ADDR_W-1:0];
            s_wdata_nxt = m_wdata[DATA_W-1:0];
            s_wstrb_nxt = m_wstrb[STRB_W-1:0];
          end
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          s_valid_nxt = 1'b0;
          m_rdata_nxt = s_rdata;
          m_ready_nxt = idx_to_onehot(gidx);
        end else if (cnt == CNT_LAST) begin
          s_valid_nxt = 1'b0;
          m_rdata_nxt = TMO_DATA;
          m_ready_nxt = idx_to_onehot(gidx);
          irq_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        m_ready_nxt = 2'b00;
      end
      default: begin
        s_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gidx        <= 1'b0;
      cnt         <= '0;
      s_valid     <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_wstrb     <= '0;
      m_ready     <= 2'b00;
      m_rdata     <= '0;
      timeout_irq <= 1'b0;
    end else begin
      gidx        <= gidx_nxt;
      cnt         <= cnt_nxt;
      s_valid     <= s_valid_nxt;
      s_addr      <= s_addr_nxt;
      s_wdata     <= s_wdata_nxt;
      s_wstrb     <= s_wstrb_nxt;
      m_ready     <= m_ready_nxt;
      m_rdata     <= m_rdata_nxt;
      timeout_irq <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        m_valid;
  logic [2*AW-1:0]   m_addr;
  logic [2*DW-1:0]   m_wdata;
  logic [2*SW-1:0]   m_wstrb;
  logic [1:0]        m_ready;
  logic [DW-1:0]     m_rdata;
  logic              s_valid;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic              s_ready;
  logic [DW-1:0]     s_rdata;
  logic              timeout_irq;

  logic [AW-1:0] ma [2];
  logic [DW-1:0] mw [2];
  logic [SW-1:0] ms [2];
  assign m_addr  = {ma[1], ma[0]};
  assign m_wdata = {mw[1], mw[0]};
  assign m_wstrb = {ms[1], ms[0]};

  int total = 0;
  int bad   = 0;
  int model_last = 1;

  // observations from the last transaction
  int            obs_wait, obs_busy;
  logic          obs_stable, obs_quiet, obs_irq, obs_irq_after;
  logic [1:0]    obs_mready, obs_mready_after;
  logic [DW-1:0] obs_rdata, obs_rdata_after, obs_swdata;
  logic [AW-1:0] obs_saddr;
  logic [SW-1:0] obs_swstrb;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .timeout_irq(timeout_irq)
  );

  // Reference model: who wins, how long the slave phase lasts, what comes back
  task automatic model_txn(input logic [1:0] req, input int delay, input logic [DW-1:0] rd,
                           output int win, output int busy, output logic tmo,
                           output logic [DW-1:0] exp_rd, output logic [1:0] exp_mr);
    if (req == 2'b01)      win = 0;
    else if (req == 2'b10) win = 1;
    else                   win = 1 - model_last;
    model_last = win;
    tmo    = (delay < 0) || (delay >= TMO);
    busy   = tmo ? TMO : delay + 1;
    exp_rd = tmo ? 32'hDEADBEEF : rd;
    exp_mr = (win == 1) ? 2'b10 : 2'b01;
  endtask

  // Drive one transaction from a negedge; slave raises s_ready on BUSY cycle delay+1
  // (delay < 0: never). mid is applied to m_valid after the grant is seen.
  task automatic do_txn(input logic [1:0] req, input int delay, input logic [DW-1:0] rd,
                        input logic [1:0] mid, input logic hold);
    int k;
    obs_stable = 1'b1; obs_quiet = 1'b1; obs_busy = 0;
    m_valid = req; s_rdata = rd; s_ready = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!s_valid && k < 20);
    obs_wait = k;
    total++;
    if (!s_valid) begin
      bad++; $display("FAIL grant_wait: s_valid=%b after %0d cycles, required 1", s_valid, k);
      m_valid = 2'b00;
      return;
    end
    obs_saddr = s_addr; obs_swdata = s_wdata; obs_swstrb = s_wstrb;
    m_valid = mid;
    while (s_valid && obs_busy < TMO + 8) begin
      obs_busy++;
      if (s_addr !== obs_saddr || s_wdata !== obs_swdata || s_wstrb !== obs_swstrb) obs_stable = 1'b0;
      if (m_ready !== 2'b00 || timeout_irq !== 1'b0) obs_quiet = 1'b0;
      s_ready = (delay >= 0) && (obs_busy == delay + 1);
      @(negedge clk);
    end
    s_ready = 1'b0;
    total++;
    if (s_valid) begin
      bad++; $display("FAIL busy_bound: s_valid still %b after %0d cycles, required 0", s_valid, obs_busy);
      m_valid = 2'b00;
      return;
    end
    obs_mready = m_ready; obs_rdata = m_rdata; obs_irq = timeout_irq;
    if (!hold) m_valid = 2'b00;
    @(negedge clk);
    obs_mready_after = m_ready; obs_irq_after = timeout_irq; obs_rdata_after = m_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_valid = 2'b00; s_ready = 1'b0; s_rdata = '0;
    for (int i = 0; i < 2; i++) begin ma[i] = '0; mw[i] = '0; ms[i] = '0; end
    repeat (2) @(negedge clk);
    total++; if (s_valid !== 1'b0)     begin bad++; $display("FAIL reset_s_valid: got %b want 0", s_valid); end
    total++; if (m_ready !== 2'b00)    begin bad++; $display("FAIL reset_m_ready: got %b want 00", m_ready); end
    total++; if (m_rdata !== '0)       begin bad++; $display("FAIL reset_m_rdata: got %h want 0", m_rdata); end
    total++; if (timeout_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", timeout_irq); end
    total++; if (s_addr !== '0 || s_wdata !== '0 || s_wstrb !== '0)
      begin bad++; $display("FAIL reset_s_bus: got %h/%h/%h want 0/0/0", s_addr, s_wdata, s_wstrb); end
    rst = 1'b0;
    model_last = 1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int win, busy; logic tmo; logic [DW-1:0] erd; logic [1:0] emr;
    ma[0] = 32'h0000_1000; ma[1] = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      logic [DW-1:0] rd;
      logic [1:0] want;
      rd = $urandom;
      want = (i % 2 == 1) ? 2'b10 : 2'b01;
      model_txn(2'b11, 0, rd, win, busy, tmo, erd, emr);
      do_txn(2'b11, 0, rd, 2'b11, i < 3);
      total++; if (obs_mready !== want) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, obs_mready, want); end
      total++; if (obs_saddr !== ma[win]) begin bad++; $display("FAIL rr_addr[%0d]: got %h want %h", i, obs_saddr, ma[win]); end
      total++; if (obs_wait !== 1 || obs_busy !== 1)
        begin bad++; $display("FAIL rr_latency[%0d]: wait=%0d busy=%0d want 1/1", i, obs_wait, obs_busy); end
      total++; if (obs_rdata !== erd) begin bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, obs_rdata, erd); end
    end
  endtask

  task automatic test_single_read();
    int win, busy; logic tmo; logic [DW-1:0] erd; logic [1:0] emr;
    ma[0] = 32'h100; ms[0] = '0; mw[0] = $urandom;
    model_txn(2'b01, 2, 32'h12345678, win, busy, tmo, erd, emr);
    do_txn(2'b01, 2, 32'h12345678, 2'b01, 1'b0);
    total++; if (obs_wait !== 1) begin bad++; $display("FAIL rd_grant_latency: got %0d want 1", obs_wait); end
    total++; if (obs_busy !== 3) begin bad++; $display("FAIL rd_s_valid_cycles: got %0d want 3", obs_busy); end
    total++; if (obs_saddr !== 32'h100 || obs_swstrb !== 4'h0)
      begin bad++; $display("FAIL rd_s_req: got %h/%h want 100/0", obs_saddr, obs_swstrb); end
    total++; if (obs_mready !== 2'b01) begin bad++; $display("FAIL rd_m_ready: got %b want 01", obs_mready); end
    total++; if (obs_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_m_rdata: got %h want 12345678", obs_rdata); end
    total++; if (obs_irq !== 1'b0) begin bad++; $display("FAIL rd_irq: got %b want 0", obs_irq); end
    total++; if (obs_mready_after !== 2'b00) begin bad++; $display("FAIL rd_ready_one_cycle: got %b want 00", obs_mready_after); end
    total++; if (obs_rdata_after !== 32'h12345678) begin bad++; $display("FAIL rd_rdata_hold: got %h want 12345678", obs_rdata_after); end
    total++; if (!obs_stable || !obs_quiet) begin bad++; $display("FAIL rd_busy_phase: stable=%b quiet=%b want 1/1", obs_stable, obs_quiet); end
  endtask

  task automatic test_write_m1();
    int win, busy; logic tmo; logic [DW-1:0] erd, rd; logic [1:0] emr;
    ma[1] = 32'h0000_2040; mw[1] = 32'hCAFEF00D; ms[1] = 4'hF;
    ma[0] = $urandom; mw[0] = $urandom; ms[0] = 4'h3;
    rd = $urandom;
    model_txn(2'b10, 3, rd, win, busy, tmo, erd, emr);
    do_txn(2'b10, 3, rd, 2'b10, 1'b0);
    total++; if (obs_swdata !== 32'hCAFEF00D) begin bad++; $display("FAIL wr_s_wdata: got %h want cafef00d", obs_swdata); end
    total++; if (obs_swstrb !== 4'hF) begin bad++; $display("FAIL wr_s_wstrb: got %h want f", obs_swstrb); end
    total++; if (obs_saddr !== 32'h2040) begin bad++; $display("FAIL wr_s_addr: got %h want 2040", obs_saddr); end
    total++; if (!obs_stable) begin bad++; $display("FAIL wr_stable: got %b want 1", obs_stable); end
    total++; if (obs_mready !== emr || obs_busy !== busy)
      begin bad++; $display("FAIL wr_done: m_ready=%b busy=%0d want %b/%0d", obs_mready, obs_busy, emr, busy); end
  endtask

  task automatic test_timeout();
    int win, busy; logic tmo; logic [DW-1:0] erd, rd; logic [1:0] emr;
    rd = $urandom;
    model_txn(2'b01, -1, rd, win, busy, tmo, erd, emr);
    do_txn(2'b01, -1, rd, 2'b01, 1'b0);
    total++; if (obs_busy !== TMO) begin bad++; $display("FAIL tmo_s_valid_cycles: got %0d want %0d", obs_busy, TMO); end
    total++; if (obs_irq !== 1'b1 || obs_mready !== 2'b01)
      begin bad++; $display("FAIL tmo_pulse: irq=%b m_ready=%b want 1/01", obs_irq, obs_mready); end
    total++; if (obs_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL tmo_rdata: got %h want deadbeef", obs_rdata); end
    total++; if (obs_irq_after !== 1'b0 || obs_mready_after !== 2'b00)
      begin bad++; $display("FAIL tmo_one_cycle: irq=%b m_ready=%b want 0/00", obs_irq_after, obs_mready_after); end
    total++; if (!obs_quiet) begin bad++; $display("FAIL tmo_busy_quiet: got %b want 1", obs_quiet); end
  endtask

  task automatic test_ready_at_last();
    int win, busy; logic tmo; logic [DW-1:0] erd, rd; logic [1:0] emr;
    for (int d = TMO - 2; d <= TMO - 1; d++) begin
      rd = $urandom;
      model_txn(2'b10, d, rd, win, busy, tmo, erd, emr);
      do_txn(2'b10, d, rd, 2'b10, 1'b0);
      total++; if (obs_irq !== 1'b0) begin bad++; $display("FAIL late_ready_irq[%0d]: got %b want 0", d, obs_irq); end
      total++; if (obs_rdata !== rd) begin bad++; $display("FAIL late_ready_rdata[%0d]: got %h want %h", d, obs_rdata, rd); end
      total++; if (obs_busy !== d + 1 || obs_mready !== 2'b10)
        begin bad++; $display("FAIL late_ready_done[%0d]: busy=%0d m_ready=%b want %0d/10", d, obs_busy, obs_mready, d + 1); end
    end
  endtask

  task automatic test_drop_and_pending();
    int win, busy; logic tmo; logic [DW-1:0] erd, rd; logic [1:0] emr, keep;
    rd = $urandom;
    model_txn(2'b01, 3, rd, win, busy, tmo, erd, emr);
    do_txn(2'b01, 3, rd, 2'b00, 1'b0);
    total++; if (obs_mready !== 2'b01 || obs_rdata !== rd)
      begin bad++; $display("FAIL drop_valid: m_ready=%b rdata=%h want 01/%h", obs_mready, obs_rdata, rd); end
    // both request; winner drops after grant, loser keeps asking and must be served next
    rd = $urandom;
    model_txn(2'b11, 1, rd, win, busy, tmo, erd, emr);
    keep = (win == 1) ? 2'b01 : 2'b10;
    do_txn(2'b11, 1, rd, keep, 1'b1);
    total++; if (obs_mready !== emr) begin bad++; $display("FAIL pending_first: got %b want %b", obs_mready, emr); end
    rd = $urandom;
    model_txn(keep, 0, rd, win, busy, tmo, erd, emr);
    do_txn(keep, 0, rd, keep, 1'b0);
    total++; if (obs_mready !== keep || obs_wait !== 1)
      begin bad++; $display("FAIL pending_served: m_ready=%b wait=%0d want %b/1", obs_mready, obs_wait, keep); end
  endtask

  task automatic test_random();
    int win, busy, delay; logic tmo; logic [DW-1:0] erd, rd; logic [1:0] emr, req;
    for (int i = 0; i < 40; i++) begin
      req = 2'($urandom_range(1, 3));
      delay = $urandom_range(0, TMO + 4);
      rd = $urandom;
      for (int j = 0; j < 2; j++) begin ma[j] = $urandom; mw[j] = $urandom; ms[j] = 4'($urandom); end
      model_txn(req, delay, rd, win, busy, tmo, erd, emr);
      do_txn(req, delay, rd, req, 1'b0);
      total++; if (obs_mready !== emr) begin bad++; $display("FAIL rnd_grant[%0d]: got %b want %b", i, obs_mready, emr); end
      total++; if (obs_saddr !== ma[win] || obs_swdata !== mw[win] || obs_swstrb !== ms[win])
        begin bad++; $display("FAIL rnd_s_req[%0d]: got %h/%h/%h want %h/%h/%h", i, obs_saddr, obs_swdata, obs_swstrb, ma[win], mw[win], ms[win]); end
      total++; if (obs_busy !== busy) begin bad++; $display("FAIL rnd_busy[%0d]: got %0d want %0d", i, obs_busy, busy); end
      total++; if (obs_irq !== tmo) begin bad++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, obs_irq, tmo); end
      total++; if (obs_rdata !== erd || obs_rdata_after !== erd)
        begin bad++; $display("FAIL rnd_rdata[%0d]: got %h/%h want %h", i, obs_rdata, obs_rdata_after, erd); end
      total++; if (!obs_stable || !obs_quiet || obs_mready_after !== 2'b00)
        begin bad++; $display("FAIL rnd_phase[%0d]: stable=%b quiet=%b after=%b want 1/1/00", i, obs_stable, obs_quiet, obs_mready_after); end
    end
  endtask

  task automatic test_reset_mid_busy();
    int k; logic seen;
    int win, busy; logic tmo; logic [DW-1:0] erd, rd; logic [1:0] emr;
    m_valid = 2'b01; s_ready = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!s_valid && k < 20);
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rstb_enter_busy: s_valid=%b want 1", s_valid); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (s_valid !== 1'b0 || m_ready !== 2'b00 || timeout_irq !== 1'b0)
      begin bad++; $display("FAIL rstb_async_ctrl: s_valid=%b m_ready=%b irq=%b want 0/00/0", s_valid, m_ready, timeout_irq); end
    total++; if (m_rdata !== '0 || s_addr !== '0 || s_wdata !== '0 || s_wstrb !== '0)
      begin bad++; $display("FAIL rstb_async_data: %h/%h/%h/%h want all 0", m_rdata, s_addr, s_wdata, s_wstrb); end
    m_valid = 2'b00;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (m_ready !== 2'b00) seen = 1'b1; end
    rst = 1'b0;
    model_last = 1;
    @(negedge clk);
    if (m_ready !== 2'b00) seen = 1'b1;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstb_no_ready: pulse seen=%b want 0", seen); end
    ma[1] = 32'h0000_3300; rd = $urandom;
    model_txn(2'b10, 1, rd, win, busy, tmo, erd, emr);
    do_txn(2'b10, 1, rd, 2'b10, 1'b0);
    total++; if (obs_mready !== 2'b10 || obs_saddr !== 32'h3300 || obs_wait !== 1)
      begin bad++; $display("FAIL rstb_after: m_ready=%b addr=%h wait=%0d want 10/3300/1", obs_mready, obs_saddr, obs_wait); end
    total++; if (obs_rdata !== rd) begin bad++; $display("FAIL rstb_after_rdata: got %h want %h", obs_rdata, rd); end
    rd = $urandom;
    model_txn(2'b11, 0, rd, win, busy, tmo, erd, emr);
    do_txn(2'b11, 0, rd, 2'b11, 1'b0);
    total++; if (obs_mready !== emr) begin bad++; $display("FAIL rstb_tie: got %b want %b", obs_mready, emr); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_write_m1();
    test_timeout();
    test_ready_at_last();
    test_drop_and_pending();
    test_random();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
